// File: rtl/mult4_pkg.sv
// mult4_pkg: shared widths, types and status bit positions for the 4x4 multiplier tile
package mult4_pkg;
    localparam int OPW = 4;
    localparam int PW  = 8;
    typedef logic [OPW-1:0] operand_t;
    typedef logic [PW-1:0]  product_t;
    localparam int ST_VALID  = 0;
    localparam int ST_ZERO   = 1;
    localparam int ST_BIG    = 2;
    localparam int ST_SQ     = 3;
    localparam int ST_PARITY = 4;
    localparam logic [7:0] STATUS_OE = 8'h1F;
endpackage

// File: rtl/mul4x4_array.sv
// mul4x4_array: combinational unsigned 4x4 array multiplier built from AND partial products and ripple adders
module mul4x4_array
    import mult4_pkg::*;
(
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output product_t       p
);
    logic [OPW-1:0] pp [OPW];
    for (genvar i = 0; i < OPW; i++) begin : g_pp
        assign pp[i] = a & {OPW{b[i]}};
    end
    // shift-and-add: each row ripples into the running upper sum and retires one product bit
    always_comb begin
        logic [OPW-1:0] r;
        logic [OPW-1:0] t;
        logic c;
        p = '0;
        t = '0;
        c = 1'b0;
        p[0] = pp[0][0];
        r = {1'b0, pp[0][OPW-1:1]};
        for (int i = 1; i < OPW; i++) begin
            c = 1'b0;
            for (int j = 0; j < OPW; j++) begin
                t[j] = r[j] ^ pp[i][j] ^ c;
                c = (r[j] & pp[i][j]) | (r[j] & c) | (pp[i][j] & c);
            end
            p[i] = t[0];
            r = {c, t[OPW-1:1]};
        end
        p[PW-1:OPW] = r;
    end
endmodule

// File: rtl/multiplicador_4x4.sv
// multiplicador_4x4: registered 4x4 unsigned multiplier tile; define MULT_STATUS_EN to drive status flags on uio
module multiplicador_4x4
    import mult4_pkg::*;
#(
    parameter int OUT_REG = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    logic [7:0] op_q;
    logic [7:0] src;
    product_t   prod;
    product_t   res;

    mul4x4_array u_arr (
        .a(op_q[7:4]),
        .b(op_q[3:0]),
        .p(prod)
    );

    // operand capture stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) op_q <= '0;
        else if (ena) op_q <= ui_in;
    end

    if (OUT_REG != 0) begin : g_oreg
        product_t   prod_q;
        logic [7:0] src_q;
        // product stage, with the operands that produced it kept alongside
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                prod_q <= '0;
                src_q  <= '0;
            end else if (ena) begin
                prod_q <= prod;
                src_q  <= op_q;
            end
        end
        assign res = prod_q;
        assign src = src_q;
    end else begin : g_comb
        assign res = prod;
        assign src = op_q;
    end

    assign uo_out = res;

`ifdef MULT_STATUS_EN
    logic valid;
    logic unused;
    assign valid  = (ui_in == op_q) && (op_q == src);
    assign unused = ^uio_in;
    assign uio_oe = STATUS_OE;
    // status flags taken from the same stage as uo_out
    always_comb begin
        uio_out            = '0;
        uio_out[ST_VALID]  = valid;
        uio_out[ST_ZERO]   = res == '0;
        uio_out[ST_BIG]    = res > product_t'(127);
        uio_out[ST_SQ]     = src[7:4] == src[3:0];
        uio_out[ST_PARITY] = ^res;
    end
`else
    logic unused;
    assign unused  = ^{uio_in, src};
    assign uio_out = '0;
    assign uio_oe  = '0;
`endif
endmodule

// File: tb/tb_multiplicador_4x4.sv
// tb_multiplicador_4x4: directed self-checking bench for the multiplier tile (both OUT_REG settings)
module tb_multiplicador_4x4;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h5A;
    logic [7:0] uo_out, uio_out, uio_oe;
    logic [7:0] uo0, uio_out0, uio_oe0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    multiplicador_4x4 #(.OUT_REG(1)) dut (
        .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    multiplicador_4x4 #(.OUT_REG(0)) dut0 (
        .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uo_out(uo0),
        .uio_in(uio_in), .uio_out(uio_out0), .uio_oe(uio_oe0)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mulx(input logic [7:0] v);
        logic [7:0] a, b;
        a = {4'h0, v[7:4]};
        b = {4'h0, v[3:0]};
        return a * b;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [7:0] vin [4] = '{8'h11, 8'h28, 8'hF3, 8'hFF};
    logic [7:0] vexp [4] = '{8'd1, 8'd16, 8'd45, 8'd225};

    initial begin
        cycles(3);
        check("reset_uo", uo_out, 8'h00);
        check("reset_uo0", uo0, 8'h00);
`ifdef MULT_STATUS_EN
        check("reset_flags", uio_out, 8'h0B);
        check("reset_oe", uio_oe, 8'h1F);
`else
        check("reset_flags", uio_out, 8'h00);
        check("reset_oe", uio_oe, 8'h00);
`endif
        rst = 1'b0;
        cycles(4);
        check("idle_zero", uo_out, 8'h00);

        for (int i = 0; i < 4; i++) begin
            ui_in = vin[i];
            cycles(4);
            check($sformatf("vec_%h", vin[i]), uo_out, vexp[i]);
            check($sformatf("vec0_%h", vin[i]), uo0, vexp[i]);
        end
`ifdef MULT_STATUS_EN
        check("ff_flags", uio_out, 8'h0D);
`else
        check("ff_flags", uio_out, 8'h00);
`endif

        for (int k = 0; k < 256; k++) begin
            ui_in = 8'(k);
            @(negedge clk);
            check($sformatf("sweep0_%0d", k), uo0, mulx(8'(k)));
            if (k > 0) check($sformatf("sweep_%0d", k - 1), uo_out, mulx(8'(k - 1)));
        end
        @(negedge clk);
        check("sweep_255", uo_out, 8'd225);

        ui_in = 8'h33;
        cycles(4);
        check("pre_change", uo_out, 8'd9);
        ui_in = 8'h44;
        @(negedge clk);
        check("change_e1", uo_out, 8'd9);
`ifdef MULT_STATUS_EN
        check("valid_e1", {7'd0, uio_out[0]}, 8'd0);
`endif
        @(negedge clk);
        check("change_e2", uo_out, 8'd16);
`ifdef MULT_STATUS_EN
        check("valid_e2", {7'd0, uio_out[0]}, 8'd1);
`endif

        ui_in = 8'h23;
        cycles(4);
        check("ena_pre", uo_out, 8'd6);
        ena = 1'b0;
        ui_in = 8'h55;
        cycles(3);
        check("ena_hold", uo_out, 8'd6);
        check("ena_hold0", uo0, 8'd6);
        ena = 1'b1;
        @(negedge clk);
        check("ena_e1", uo_out, 8'd6);
        @(negedge clk);
        check("ena_e2", uo_out, 8'd25);

        ui_in = 8'hF3;
        cycles(4);
        check("rst_pre", uo_out, 8'd45);
        #2 rst = 1'b1;
        #1;
        check("rst_async", uo_out, 8'd0);
        check("rst_async0", uo0, 8'd0);
        @(negedge clk);
        check("rst_held", uo_out, 8'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_e1", uo_out, 8'd0);
        check("rst_e1_0", uo0, 8'd45);
        @(negedge clk);
        check("rst_e2", uo_out, 8'd45);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
